// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//   Multi-cycle multiply/divide sequencer and HI/LO register file for the
//   5-stage pipeline. The E stage issues mult/multu/div/divu/mthi/mtlo with
//   forwarded operands. The 64-bit result is computed when the operation is
//   issued and held in pend_hi/pend_lo. It is committed to HI/LO after a
//   fixed latency, so downstream timing matches a real iterative unit.
//
// Ports
//   clk       in   1   rising-edge clock
//   reset     in   1   asynchronous, active-high; clears all state
//   start     in   1   E-stage md instruction valid (one cycle per instruction)
//   op        in   3   000 mult, 001 multu, 010 div, 011 divu, 100 mthi,
//                      101 mtlo, 110/111 no-op
//   srcA      in   32  forwarded rs value
//   srcB      in   32  forwarded rt value
//   D_md_use  in   1   instruction in D is md-class
//   busy      out  1   multiply/divide in flight
//   hi        out  32  HI register
//   lo        out  32  LO register
//   md_stall  out  1   stall request to the hazard unit
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        D_md_use,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      hi_reg, lo_reg;
  logic [31:0]      pend_hi_reg, pend_lo_reg;

  // Multiply/divide issue only from IDLE. A start while BUSY is dropped.
  logic issue_md;
  logic finish;

  assign issue_md = (state_reg == IDLE) && start && !op[2];
  assign finish   = (state_reg == BUSY) && (cnt_reg == CNT_W'(1));

  // ---------------------------------------------------------------------------
  // Arithmetic. op[1] selects divide, and op[0]=0 selects the signed form.
  // Division works on magnitudes, and the signs are applied afterwards. This
  // gives truncation toward zero with the remainder taking the dividend's sign.
  // It also makes 8000_0000 / FFFF_FFFF come out as 8000_0000 rem 0 with no
  // special case.
  // ---------------------------------------------------------------------------
  logic        is_signed;
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic [63:0] md_result;

  always_comb begin
    is_signed = !op[0];

    a_ext = is_signed ? {{32{srcA[31]}}, srcA} : {32'd0, srcA};
    b_ext = is_signed ? {{32{srcB[31]}}, srcB} : {32'd0, srcB};
    prod  = a_ext * b_ext;

    a_neg = is_signed && srcA[31];
    b_neg = is_signed && srcB[31];
    a_mag = a_neg ? (32'd0 - srcA) : srcA;
    b_mag = b_neg ? (32'd0 - srcB) : srcB;
    q_mag = 32'd0;
    r_mag = 32'd0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem  = a_neg ? (32'd0 - r_mag) : r_mag;

    // Divide-by-zero gives an all-ones quotient and returns the dividend.
    if (srcB == 32'd0) begin
      quot = 32'hFFFF_FFFF;
      rem  = srcA;
    end

    md_result = op[1] ? {rem, quot} : prod;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (issue_md) begin
          state_next = BUSY;
          cnt_next   = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      BUSY: begin
        if (finish) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. md_stall also covers the issue cycle itself. This lets an
  // mfhi/mflo sitting in D wait for the result instead of reading the old HI/LO.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy     = (state_reg == BUSY);
    md_stall = D_md_use && ((state_reg == BUSY) || (start && !op[2]));
  end

  // ---------------------------------------------------------------------------
  // HI/LO and pending result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_reg      <= '0;
      lo_reg      <= '0;
      pend_hi_reg <= '0;
      pend_lo_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (issue_md) begin
        pend_hi_reg <= md_result[63:32];
        pend_lo_reg <= md_result[31:0];
      end else if (start && op == OP_MTHI) begin
        hi_reg <= srcA;
      end else if (start && op == OP_MTLO) begin
        lo_reg <= srcA;
      end
    end else if (finish) begin
      hi_reg <= pend_hi_reg;
      lo_reg <= pend_lo_reg;
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srcA, srcB;
  logic        D_md_use;
  logic        busy;
  logic [31:0] hi, lo;
  logic        md_stall;

  muldiv_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .srcA     (srcA),
    .srcB     (srcB),
    .D_md_use (D_md_use),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .md_stall (md_stall)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010,
                         DIVU = 3'b011, MTHI = 3'b100, MTLO = 3'b101;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[12];

  int checks = 0;
  int errors = 0;
  int busy_run = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one start pulse. This is called at a negedge and returns at the next negedge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] h, input logic [31:0] l, input int c);
    exp_t e;
    e.hi = h; e.lo = l; e.cycles = c;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending results, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: it measures the length of each busy pulse. When busy falls it compares HI/LO.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en) begin
      if (busy) begin
        busy_run++;
      end else if (busy_run > 0) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got unexpected result hi=%h lo=%h, expected none", hi, lo);
        end else begin
          e = sb_q.pop_front();
          $display("txn: busy %0d cycles, hi=%h lo=%h (exp %0d, %h, %h)",
                   busy_run, hi, lo, e.cycles, e.hi, e.lo);
          check("busy_len", 32'(busy_run), 32'(e.cycles));
          check("hi", hi, e.hi);
          check("lo", lo, e.lo);
        end
        busy_run = 0;
      end
    end
  end

  initial begin
    int n;
    vecs[0]  = '{MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
    vecs[1]  = '{DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        10};
    vecs[2]  = '{DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3]  = '{DIV,   32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 10};
    vecs[4]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 10};
    vecs[5]  = '{MULTU, 32'hFFFF_FFFF, 32'd2,        32'd1,         32'hFFFF_FFFE, 5};
    vecs[6]  = '{MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,        32'd1,         5};
    vecs[7]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,        5};
    vecs[8]  = '{DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
    vecs[9]  = '{DIVU,  32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 10};
    vecs[10] = '{DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,        10};
    vecs[11] = '{DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        10};

    reset = 1'b1; start = 1'b0; op = 3'b000; srcA = '0; srcB = '0; D_md_use = 1'b1;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_stall", {31'd0, md_stall}, 32'd0);
    D_md_use = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    // Run the table of arithmetic vectors.
    foreach (vecs[i]) begin
      push_exp(vecs[i].hi, vecs[i].lo, vecs[i].cycles);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_drain("vec");
    end

    // Back-to-back: the second start is issued in the cycle where busy falls.
    push_exp(32'd0, 32'd12, 5);
    issue(MULT, 32'd3, 32'd4);
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    check("b2b_busy_fell", {31'd0, busy}, 32'd0);
    push_exp(32'd2, 32'd14, 10);
    issue(DIVU, 32'd100, 32'd7);
    wait_drain("b2b");

    // Test mthi and mtlo on consecutive cycles, then an undefined op.
    start = 1'b1; op = MTHI; srcA = 32'h0000_AAAA;
    #1 check("mthi_stall", {31'd0, md_stall}, 32'd0);
    @(negedge clk);
    op = MTLO; srcA = 32'h0000_5555;
    check("mthi_hi", hi, 32'h0000_AAAA);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    op = 3'b110; srcA = 32'h1234_5678; srcB = 32'h1;
    check("mtlo_lo", lo, 32'h0000_5555);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("undef_busy", {31'd0, busy}, 32'd0);
    check("undef_hi", hi, 32'h0000_AAAA);
    check("undef_lo", lo, 32'h0000_5555);
    $display("txn: mthi/mtlo/undef hi=%h lo=%h", hi, lo);

    // Check md_stall across the issue cycle and the busy window. A second
    // start while busy must be ignored.
    D_md_use = 1'b1;
    push_exp(32'd0, 32'd12, 5);
    start = 1'b1; op = MULT; srcA = 32'd3; srcB = 32'd4;
    #1 check("stall_issue", {31'd0, md_stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check("stall_busy", {31'd0, busy}, 32'd1);
      check("stall_hold", {31'd0, md_stall}, 32'd1);
      if (i == 2) begin start = 1'b1; op = MULT; srcA = 32'd5; srcB = 32'd5; end
      @(negedge clk);
      start = 1'b0;
    end
    check("stall_end_busy", {31'd0, busy}, 32'd0);
    check("stall_end", {31'd0, md_stall}, 32'd0);
    D_md_use = 1'b0;
    wait_drain("stall");

    // Reset in the middle of a divide.
    mon_en = 1'b0;
    issue(DIV, 32'd100, 32'd3);
    @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_hi", hi, 32'd0);
    check("async_rst_lo", lo, 32'd0);
    @(negedge clk); @(negedge clk);
    check("held_rst_hi", hi, 32'd0);
    reset = 1'b0;
    busy_run = 0;
    mon_en = 1'b1;
    push_exp(32'd1, 32'hFFFF_FFFE, 5);
    issue(MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
